// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR sequence generator.
package lfsr_pkg;

   // Transaction FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fsm_state_e;

   // Feedback mask for x^32 taps at bits 31, 29, 25, 24.
   localparam logic [31:0] DEFAULT_TAPS_32 = 32'hA300_0000;
   // Reset seed; also replaces a zero seed when the zero-seed guard is built in.
   localparam logic [31:0] DEFAULT_SEED_32 = 32'hFFFF_FFFF;

endpackage : lfsr_pkg

// File: rtl/lfsr_core.sv
// Fibonacci LFSR core: seed load port, step enable, STEPS steps unrolled per clock.
// step_bits_c carries the feedback bits of this cycle's steps, earliest step in the MSB.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int unsigned       LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS_32),
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED_32),
   parameter int unsigned       STEPS  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step_en,
   output logic [STEPS-1:0]  step_bits_c
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_adv;
   logic [LFSR_W-1:0] walk;
   logic              fb;

   // Unrolled STEPS-deep feedback walk from the current state.
   always_comb begin
      walk        = state_q;
      fb          = 1'b0;
      step_bits_c = '0;
      for (int i = 0; i < STEPS; i++) begin
         fb                         = ^(walk & TAPS);
         step_bits_c[STEPS - 1 - i] = fb;
         walk                       = {walk[LFSR_W-2:0], fb};
      end
      state_adv = walk;
   end

   // State register: load has priority, otherwise advance only when enabled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= SEED;
      end else if (load) begin
         state_q <= load_val;
      end else if (step_en) begin
         state_q <= state_adv;
      end
   end

endmodule : lfsr_core

// File: rtl/lfsr_seq_gen.sv
// LFSR random sequence generator with start/done transaction and valid/ready output.
// Optional build macro: LFSR_ZERO_SEED_GUARD_EN (zero seed replaced by SEED, sticky seed_err).
module lfsr_seq_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned       LFSR_W         = 32,
   parameter logic [LFSR_W-1:0] TAPS           = LFSR_W'(DEFAULT_TAPS_32),
   parameter logic [LFSR_W-1:0] SEED           = LFSR_W'(DEFAULT_SEED_32),
   parameter int unsigned       SEQ_BITS       = 256,
   parameter int unsigned       PAD_BITS       = 32,
   parameter int unsigned       BITS_PER_CYCLE = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         seed_load,
   input  logic [LFSR_W-1:0]            seed_in,
   input  logic                         start,
   output logic                         busy,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SEQ_BITS+PAD_BITS-1:0] random_sequence,
   output logic                         seed_err
);

   localparam int unsigned OUT_W     = SEQ_BITS + PAD_BITS;
   localparam int unsigned RUN_STEPS = SEQ_BITS / BITS_PER_CYCLE;
   localparam int unsigned CNT_W     = $clog2(RUN_STEPS + 1);

   fsm_state_e              state_q, state_n;
   logic [CNT_W-1:0]        cnt_q, cnt_n;
   logic [SEQ_BITS-1:0]     seq_q, seq_n, seq_shift;
   logic                    busy_n, valid_n;
   logic [OUT_W-1:0]        rs_n;
   logic                    lfsr_load, lfsr_step;
   logic [LFSR_W-1:0]       load_val;
   logic [BITS_PER_CYCLE-1:0] step_bits;

   lfsr_core #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .SEED   (SEED),
      .STEPS  (BITS_PER_CYCLE)
   ) u_core (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (lfsr_load),
      .load_val    (load_val),
      .step_en     (lfsr_step),
      .step_bits_c (step_bits)
   );

   // New bits enter at the LSB so the first generated bit ends at the MSB.
   assign seq_shift = SEQ_BITS'({seq_q, step_bits});

`ifdef LFSR_ZERO_SEED_GUARD_EN
   logic zero_seed;

   assign zero_seed = (seed_in == '0);
   assign load_val  = zero_seed ? SEED : seed_in;

   // Sticky record of any zero-seed load attempt, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seed_err <= 1'b0;
      end else if (lfsr_load && zero_seed) begin
         seed_err <= 1'b1;
      end
   end
`else
   assign load_val = seed_in;
   assign seed_err = 1'b0;
`endif

   // Next-state and next-output logic for the IDLE/FILL/DONE transaction.
   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      seq_n     = seq_q;
      busy_n    = busy;
      valid_n   = out_valid;
      rs_n      = random_sequence;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            lfsr_load = seed_load;
            if (start) begin
               state_n = FILL;
               cnt_n   = CNT_W'(RUN_STEPS);
               busy_n  = 1'b1;
            end
         end
         FILL: begin
            lfsr_step = 1'b1;
            seq_n     = seq_shift;
            if (cnt_q == CNT_W'(1)) begin
               state_n = DONE;
               valid_n = 1'b1;
               rs_n    = OUT_W'(seq_shift) << PAD_BITS;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n = IDLE;
               valid_n = 1'b0;
               rs_n    = '0;
               seq_n   = '0;
               busy_n  = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
            rs_n    = '0;
            seq_n   = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

   // FSM, counter, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         seq_q           <= '0;
         busy            <= 1'b0;
         out_valid       <= 1'b0;
         random_sequence <= '0;
      end else begin
         state_q         <= state_n;
         cnt_q           <= cnt_n;
         seq_q           <= seq_n;
         busy            <= busy_n;
         out_valid       <= valid_n;
         random_sequence <= rs_n;
      end
   end

endmodule : lfsr_seq_gen

// File: tb/tb_lfsr_seq_gen.sv
// Directed bench for lfsr_seq_gen: vector table of transactions plus reset/zero-seed/8-bit-step cases.
module tb_lfsr_seq_gen;

   localparam int unsigned OUT_W = 288;
   localparam logic [31:0] TAPS  = 32'hA300_0000;
   localparam logic [31:0] SEED  = 32'hFFFF_FFFF;
`ifdef LFSR_ZERO_SEED_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      bit          do_load;
      logic [31:0] seed;
      int          ready_delay;
      bit          ready_early;
      bit          poke;
      bit          chk_top;
      logic [31:0] exp_top;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset_n, seed_load, start, out_ready;
   logic [31:0]      seed_in;
   logic             busy, out_valid, seed_err;
   logic [OUT_W-1:0] random_sequence;

   logic             sl8, start8, ready8;
   logic [31:0]      seed_in8;
   logic             busy8, valid8, seed_err8;
   logic [OUT_W-1:0] rs8;

   int               checks = 0;
   int               errors = 0;
   logic [31:0]      m_state;
   vec_t             vecs[5];

   lfsr_seq_gen u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .seed_load       (seed_load),
      .seed_in         (seed_in),
      .start           (start),
      .busy            (busy),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .random_sequence (random_sequence),
      .seed_err        (seed_err)
   );

   lfsr_seq_gen #(.BITS_PER_CYCLE(8)) u_dut8 (
      .clk             (clk),
      .reset_n         (reset_n),
      .seed_load       (sl8),
      .seed_in         (seed_in8),
      .start           (start8),
      .busy            (busy8),
      .out_valid       (valid8),
      .out_ready       (ready8),
      .random_sequence (rs8),
      .seed_err        (seed_err8)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] model_seq(input logic [31:0] st, output logic [31:0] st_end);
      logic [255:0] s;
      logic [31:0]  r;
      logic         fb;
      s = '0;
      r = st;
      for (int i = 0; i < 256; i++) begin
         fb = ^(r & TAPS);
         s  = {s[254:0], fb};
         r  = {r[30:0], fb};
      end
      st_end = r;
      return s;
   endfunction

   task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full transaction on u_dut, checked against the model and the vector's hand value.
   task automatic run_txn(input vec_t v, input string tag);
      logic [255:0]     exp_seq;
      logic [31:0]      nxt;
      logic [OUT_W-1:0] held;
      int               cnt;
      if (v.do_load) m_state = (GUARD && v.seed == 32'h0) ? SEED : v.seed;
      exp_seq   = model_seq(m_state, nxt);
      seed_load = v.do_load;
      seed_in   = v.seed;
      start     = 1'b1;
      out_ready = v.ready_early;
      @(negedge clk);
      seed_load = 1'b0;
      start     = 1'b0;
      chk({tag, "_busy_fill"}, OUT_W'(busy), OUT_W'(1));
      cnt = 0;
      while (!out_valid && cnt < 400) begin
         if (v.poke && cnt == 50) begin
            start     = 1'b1;
            seed_load = 1'b1;
            seed_in   = 32'h1234_5678;
         end
         @(negedge clk);
         start     = 1'b0;
         seed_load = 1'b0;
         cnt++;
      end
      chk({tag, "_latency"}, OUT_W'(cnt), OUT_W'(256));
      if (!out_valid) begin
         out_ready = 1'b0;
         return;
      end
      chk({tag, "_seq"}, random_sequence, {exp_seq, 32'h0});
      if (v.chk_top) chk({tag, "_top32"}, OUT_W'(random_sequence[287:256]), OUT_W'(v.exp_top));
      held = random_sequence;
      for (int i = 0; i < v.ready_delay; i++) begin
         if (v.poke && i == 0) begin
            start     = 1'b1;
            seed_load = 1'b1;
            seed_in   = 32'h0;
         end
         @(negedge clk);
         start     = 1'b0;
         seed_load = 1'b0;
         chk({tag, "_hold"}, {random_sequence[OUT_W-1:2], out_valid, busy}, {held[OUT_W-1:2], 2'b11});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_release"}, {random_sequence, out_valid, busy}, '0);
      m_state = nxt;
   endtask

   initial begin
      vec_t             v;
      logic [255:0]     seq_seed;
      logic [31:0]      dummy;
      int               cnt;

      vecs[0] = '{1'b0, 32'h0000_0000, 0,  1'b0, 1'b0, 1'b1, 32'h0000_0043};
      vecs[1] = '{1'b1, 32'h0000_0001, 10, 1'b0, 1'b1, 1'b1, 32'h0000_00C5};
      vecs[2] = '{1'b0, 32'h0000_0000, 0,  1'b1, 1'b0, 1'b0, 32'h0000_0000};
      vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1,  1'b0, 1'b0, 1'b1, 32'h0000_0043};
      vecs[4] = '{1'b1, 32'h8000_0000, 2,  1'b0, 1'b1, 1'b0, 32'h0000_0000};

      reset_n   = 1'b0;
      seed_load = 1'b0;
      seed_in   = 32'h0;
      start     = 1'b0;
      out_ready = 1'b0;
      sl8       = 1'b0;
      seed_in8  = 32'h0;
      start8    = 1'b0;
      ready8    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {random_sequence, out_valid, busy, seed_err}, '0);
      chk("reset_outputs8", {rs8, valid8, busy8, seed_err8}, '0);
      reset_n = 1'b1;
      m_state = SEED;
      seq_seed = model_seq(SEED, dummy);

      // Ready asserted with nothing valid must not disturb IDLE.
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready", {random_sequence, out_valid, busy}, '0);
      out_ready = 1'b0;

      // Eight steps per clock: same stream, 32-cycle latency.
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cnt = 0;
      while (!valid8 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("bpc8_latency", OUT_W'(cnt), OUT_W'(32));
      chk("bpc8_seq", rs8, {seq_seed, 32'h0});
      chk("bpc8_top32", OUT_W'(rs8[287:256]), OUT_W'(32'h43));
      ready8 = 1'b1;
      @(negedge clk);
      ready8 = 1'b0;
      chk("bpc8_release", {rs8, valid8, busy8}, '0);

      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of FILL aborts; the next run restarts from SEED.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      chk("midfill_busy", {out_valid, busy}, OUT_W'(2'b01));
      reset_n = 1'b0;
      @(negedge clk);
      chk("midfill_reset", {random_sequence, out_valid, busy}, '0);
      reset_n = 1'b1;
      m_state = SEED;
      @(negedge clk);
      v = '{1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0043};
      run_txn(v, "after_reset");

      // Zero seed: substituted by SEED with the guard, lock-up without it.
      v = '{1'b1, 32'h0, 0, 1'b0, 1'b0, 1'b1, (GUARD ? 32'h0000_0043 : 32'h0)};
      run_txn(v, "zero_seed");
      chk("zero_seed_err", OUT_W'(seed_err), OUT_W'(GUARD));
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("seed_err_cleared", OUT_W'(seed_err), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_lfsr_seq_gen
